// File: rtl/csr_exc_ctrl_if.sv
// Signal bundle between the WB stage / CSR file / fetch and csr_exc_ctrl.
// master drives the event and CSR-side inputs; slave is the sequencer's view.
interface csr_exc_ctrl_if;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [4:0]  wb_ex_vec;
  logic        wb_ertn;
  logic [12:0] int_pending;
  logic        crmd_ie;
  logic [31:0] ex_entry;
  logic [31:0] era;
  logic        wb_accept;
  logic        ex_commit;
  logic [5:0]  ex_ecode;
  logic [8:0]  ex_esubcode;
  logic [31:0] ex_pc;
  logic        ertn_commit;
  logic        pipe_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        timer_int;
  logic        tcfg_we;
  logic [31:0] tcfg_wvalue;
  logic        ticlr_clr;
  logic [31:0] tval;

  modport master (
    output wb_valid, wb_pc, wb_ex_vec, wb_ertn, int_pending, crmd_ie, ex_entry, era,
           redirect_ready, tcfg_we, tcfg_wvalue, ticlr_clr,
    input  wb_accept, ex_commit, ex_ecode, ex_esubcode, ex_pc, ertn_commit, pipe_flush,
           redirect_valid, redirect_pc, timer_int, tval
  );

  modport slave (
    input  wb_valid, wb_pc, wb_ex_vec, wb_ertn, int_pending, crmd_ie, ex_entry, era,
           redirect_ready, tcfg_we, tcfg_wvalue, ticlr_clr,
    output wb_accept, ex_commit, ex_ecode, ex_esubcode, ex_pc, ertn_commit, pipe_flush,
           redirect_valid, redirect_pc, timer_int, tval
  );
endinterface

// File: rtl/csr_exc_ctrl.sv
// Exception/interrupt/ertn sequencer: IDLE -> COMMIT -> FLUSH -> REDIR -> IDLE.
// Define CSR_TIMER_EN to build the optional 32-bit countdown timer.
module csr_exc_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic           clk,
  input logic           resetn,
  csr_exc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCommit, StFlush, StRedir} state_e;

  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_ex_q, is_ex_d;
  logic [5:0]  ecode_q, ecode_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        timer_int;
  logic [12:0] int_eff;
  logic        int_taken;
  logic        take_ex;

  assign int_eff   = bus.int_pending | {1'b0, timer_int, 11'b0};
  assign int_taken = bus.crmd_ie & (|int_eff);
  assign take_ex   = int_taken | (|bus.wb_ex_vec);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_ex_d    = is_ex_q;
    ecode_d    = ecode_q;
    pc_d       = pc_q;
    redir_pc_d = redir_pc_q;
    unique case (state_q)
      StIdle: begin
        if (bus.wb_valid && (take_ex || bus.wb_ertn)) begin
          state_d = StCommit;
          pc_d    = bus.wb_pc;
          is_ex_d = take_ex;
          if (int_taken)              ecode_d = 6'h00;
          else if (bus.wb_ex_vec[0])  ecode_d = 6'h08;
          else if (bus.wb_ex_vec[1])  ecode_d = 6'h0D;
          else if (bus.wb_ex_vec[2])  ecode_d = 6'h0B;
          else if (bus.wb_ex_vec[3])  ecode_d = 6'h0C;
          else if (bus.wb_ex_vec[4])  ecode_d = 6'h09;
          else                        ecode_d = 6'h00;
        end
      end
      StCommit: begin
        redir_pc_d = is_ex_q ? bus.ex_entry : bus.era;
        cnt_d      = FlushLoad;
        // Redirect lands FLUSH_CYCLES after the commit cycle.
        state_d    = (FLUSH_CYCLES <= 1) ? StRedir : StFlush;
      end
      StFlush: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = StRedir;
      end
      StRedir: begin
        if (bus.redirect_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_ex_q    <= 1'b0;
      ecode_q    <= '0;
      pc_q       <= '0;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_ex_q    <= is_ex_d;
      ecode_q    <= ecode_d;
      pc_q       <= pc_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign bus.wb_accept      = (state_q == StIdle);
  assign bus.ex_commit      = (state_q == StCommit) & is_ex_q;
  assign bus.ertn_commit    = (state_q == StCommit) & ~is_ex_q;
  assign bus.ex_ecode       = bus.ex_commit ? ecode_q : 6'h00;
  assign bus.ex_esubcode    = 9'h000;
  assign bus.ex_pc          = bus.ex_commit ? pc_q : 32'h0;
  assign bus.pipe_flush     = (state_q != StIdle);
  assign bus.redirect_valid = (state_q == StRedir);
  assign bus.redirect_pc    = redir_pc_q;

`ifdef CSR_TIMER_EN
  logic        tmr_en_q;
  logic        tmr_per_q;
  logic        timer_int_q;
  logic [29:0] tmr_init_q;
  logic [31:0] tval_q;
  logic        tmr_fire;

  // A TCFG write in the same cycle pre-empts expiry and counting.
  assign tmr_fire = ~bus.tcfg_we & tmr_en_q & (tval_q == 32'h0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmr_en_q    <= 1'b0;
      tmr_per_q   <= 1'b0;
      tmr_init_q  <= '0;
      tval_q      <= '0;
      timer_int_q <= 1'b0;
    end else begin
      if (bus.tcfg_we) begin
        tmr_en_q   <= bus.tcfg_wvalue[0];
        tmr_per_q  <= bus.tcfg_wvalue[1];
        tmr_init_q <= bus.tcfg_wvalue[31:2];
        if (bus.tcfg_wvalue[0]) tval_q <= {bus.tcfg_wvalue[31:2], 2'b00};
      end else if (tmr_fire) begin
        if (tmr_per_q) begin
          tval_q <= {tmr_init_q, 2'b00};
        end else begin
          tval_q   <= 32'hFFFF_FFFF;
          tmr_en_q <= 1'b0;
        end
      end else if (tmr_en_q) begin
        tval_q <= tval_q - 32'd1;
      end
      if (tmr_fire)           timer_int_q <= 1'b1;
      else if (bus.ticlr_clr) timer_int_q <= 1'b0;
    end
  end

  assign timer_int     = timer_int_q;
  assign bus.timer_int = timer_int_q;
  assign bus.tval      = tval_q;
`else
  logic unused_timer_in;
  assign unused_timer_in = bus.tcfg_we ^ bus.ticlr_clr ^ (^bus.tcfg_wvalue);
  assign timer_int       = 1'b0;
  assign bus.timer_int   = 1'b0;
  assign bus.tval        = 32'h0;
`endif

endmodule

// File: tb/tb_csr_exc_ctrl.sv
// Bench for csr_exc_ctrl: directed scenarios, then random transactions checked
// against a priority-table reference model. Timer checks follow CSR_TIMER_EN.
module tb_csr_exc_ctrl;
  localparam int unsigned FC = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  logic model_timer_int = 1'b0;

  csr_exc_ctrl_if bus ();
  csr_exc_ctrl #(.FLUSH_CYCLES(FC)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "simulation timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 no event, 1 exception/interrupt, 2 ertn
  function automatic void ref_event(input logic [4:0] vec, input logic ertn,
                                    input logic [12:0] intp, input logic ie,
                                    output int kind, output logic [5:0] code);
    logic [5:0] codes [5];
    codes = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
    kind = 0;
    code = 6'h00;
    if (ie && (intp != 13'h0 || model_timer_int)) begin
      kind = 1;
      return;
    end
    for (int i = 0; i < 5; i++) begin
      if (vec[i]) begin
        kind = 1;
        code = codes[i];
        return;
      end
    end
    if (ertn) kind = 2;
  endfunction

  task automatic idle_inputs();
    bus.wb_valid       = 1'b0;
    bus.wb_ex_vec      = 5'h0;
    bus.wb_ertn        = 1'b0;
    bus.int_pending    = 13'h0;
    bus.redirect_ready = 1'b0;
    bus.tcfg_we        = 1'b0;
    bus.ticlr_clr      = 1'b0;
  endtask

  task automatic run_txn(input logic [31:0] pc, input logic [4:0] vec, input logic ertn,
                         input logic [12:0] intp, input logic ie, input logic [31:0] entry,
                         input logic [31:0] era_v, input int hold, input bit junk);
    int         kind;
    logic [5:0] code;
    logic [31:0] exp_pc;
    chk("accept_pre", bus.wb_accept, 1);
    bus.wb_valid    = 1'b1;
    bus.wb_pc       = pc;
    bus.wb_ex_vec   = vec;
    bus.wb_ertn     = ertn;
    bus.int_pending = intp;
    bus.crmd_ie     = ie;
    bus.ex_entry    = entry;
    bus.era         = era_v;
    ref_event(vec, ertn, intp, ie, kind, code);
    exp_pc = (kind == 1) ? entry : era_v;
    tick();
    if (kind == 0) begin
      chk("none_ex_commit", bus.ex_commit, 0);
      chk("none_ertn_commit", bus.ertn_commit, 0);
      chk("none_flush", bus.pipe_flush, 0);
      chk("none_accept", bus.wb_accept, 1);
      idle_inputs();
      return;
    end
    chk("ex_commit", bus.ex_commit, (kind == 1));
    chk("ertn_commit", bus.ertn_commit, (kind == 2));
    if (kind == 1) begin
      chk("ecode", bus.ex_ecode, code);
      chk("esubcode", bus.ex_esubcode, 0);
      chk("ex_pc", bus.ex_pc, pc);
    end
    chk("commit_flush", bus.pipe_flush, 1);
    chk("commit_accept", bus.wb_accept, 0);
    if (junk) begin
      bus.wb_valid    = 1'b1;
      bus.wb_ex_vec   = 5'($urandom);
      bus.wb_ertn     = 1'($urandom);
      bus.int_pending = 13'($urandom);
    end else begin
      idle_inputs();
    end
    tick();
    bus.ex_entry = $urandom;
    bus.era      = $urandom;
    for (int k = 1; k < FC; k++) begin
      chk("flush_flush", bus.pipe_flush, 1);
      chk("flush_rv", bus.redirect_valid, 0);
      chk("flush_no_commit", bus.ex_commit | bus.ertn_commit, 0);
      tick();
    end
    chk("redir_valid", bus.redirect_valid, 1);
    chk("redir_pc", bus.redirect_pc, exp_pc);
    chk("redir_flush", bus.pipe_flush, 1);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", bus.redirect_valid, 1);
      chk("hold_pc", bus.redirect_pc, exp_pc);
      chk("hold_accept", bus.wb_accept, 0);
      chk("hold_no_commit", bus.ex_commit | bus.ertn_commit, 0);
    end
    idle_inputs();
    bus.redirect_ready = 1'b1;
    tick();
    bus.redirect_ready = 1'b0;
    chk("done_valid", bus.redirect_valid, 0);
    chk("done_flush", bus.pipe_flush, 0);
    chk("done_accept", bus.wb_accept, 1);
  endtask

  initial begin
    logic [4:0] rv;
    logic [12:0] ri;
    idle_inputs();
    bus.wb_pc       = 32'h0;
    bus.crmd_ie     = 1'b0;
    bus.ex_entry    = 32'h0;
    bus.era         = 32'h0;
    bus.tcfg_wvalue = 32'h0;
    tick();
    tick();
    chk("rst_accept", bus.wb_accept, 1);
    chk("rst_ex_commit", bus.ex_commit, 0);
    chk("rst_ertn", bus.ertn_commit, 0);
    chk("rst_flush", bus.pipe_flush, 0);
    chk("rst_rv", bus.redirect_valid, 0);
    chk("rst_rpc", bus.redirect_pc, 0);
    chk("rst_tint", bus.timer_int, 0);
    chk("rst_tval", bus.tval, 0);
    resetn = 1'b1;
    tick();
    chk("post_rst_accept", bus.wb_accept, 1);

    // Directed scenarios
    run_txn(32'h1c000100, 5'b00100, 1'b0, 13'h0, 1'b0, 32'h1c008000, 32'h0, 0, 1'b0);
    run_txn(32'h1c000110, 5'b10001, 1'b0, 13'h004, 1'b1, 32'h1c008000, 32'h0, 1, 1'b0);
    run_txn(32'h1c000120, 5'b10001, 1'b0, 13'h004, 1'b0, 32'h1c008000, 32'h0, 0, 1'b0);
    run_txn(32'h1c000200, 5'b00000, 1'b1, 13'h0, 1'b1, 32'h1c008000, 32'h1c000204, 0, 1'b0);
    run_txn(32'h1c000300, 5'b01000, 1'b0, 13'h0, 1'b0, 32'h1c008040, 32'h0, 5, 1'b1);
    run_txn(32'h1c000310, 5'b00000, 1'b0, 13'h0, 1'b1, 32'h1c008040, 32'h0, 0, 1'b0);

    // Reset during FLUSH
    bus.wb_valid  = 1'b1;
    bus.wb_pc     = 32'h1c000400;
    bus.wb_ex_vec = 5'b00010;
    bus.ex_entry  = 32'h1c00a000;
    tick();
    idle_inputs();
    tick();
    chk("pre_rst_flush", bus.pipe_flush, 1);
    #1 resetn = 1'b0;
    #1;
    chk("arst_flush", bus.pipe_flush, 0);
    chk("arst_rv", bus.redirect_valid, 0);
    chk("arst_rpc", bus.redirect_pc, 0);
    chk("arst_commit", bus.ex_commit | bus.ertn_commit, 0);
    chk("arst_ecode", bus.ex_ecode, 0);
    chk("arst_ex_pc", bus.ex_pc, 0);
    chk("arst_accept", bus.wb_accept, 1);
    #1 resetn = 1'b1;
    tick();
    chk("arst_release_accept", bus.wb_accept, 1);
    chk("arst_release_flush", bus.pipe_flush, 0);

`ifdef CSR_TIMER_EN
    bus.tcfg_we     = 1'b1;
    bus.tcfg_wvalue = 32'h0000_0009;
    tick();
    bus.tcfg_we = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      chk("tmr_count", bus.tval, 32'(8 - k));
      chk("tmr_int_low", bus.timer_int, 0);
      tick();
    end
    chk("tmr_oneshot_int", bus.timer_int, 1);
    chk("tmr_oneshot_tval", bus.tval, 32'hFFFF_FFFF);
    tick();
    chk("tmr_stopped_tval", bus.tval, 32'hFFFF_FFFF);
    model_timer_int = 1'b1;
    run_txn(32'h1c000500, 5'b00000, 1'b0, 13'h0, 1'b1, 32'h1c00c000, 32'h0, 0, 1'b0);
    bus.ticlr_clr = 1'b1;
    tick();
    bus.ticlr_clr = 1'b0;
    model_timer_int = 1'b0;
    chk("tmr_clr", bus.timer_int, 0);
    bus.tcfg_we     = 1'b1;
    bus.tcfg_wvalue = 32'h0000_000B;
    tick();
    bus.tcfg_we = 1'b0;
    chk("tmr_per_load", bus.tval, 8);
    for (int k = 0; k < 9; k++) tick();
    chk("tmr_per_int", bus.timer_int, 1);
    chk("tmr_per_reload", bus.tval, 8);
    tick();
    chk("tmr_per_count", bus.tval, 7);
    bus.ticlr_clr = 1'b1;
    tick();
    bus.ticlr_clr = 1'b0;
    chk("tmr_per_clr", bus.timer_int, 0);
    for (int k = 0; k < 6; k++) tick();
    chk("tmr_per_zero", bus.tval, 0);
    bus.ticlr_clr = 1'b1;
    tick();
    bus.ticlr_clr = 1'b0;
    chk("tmr_set_wins", bus.timer_int, 1);
    bus.tcfg_we     = 1'b1;
    bus.tcfg_wvalue = 32'h0;
    tick();
    bus.tcfg_we   = 1'b0;
    bus.ticlr_clr = 1'b1;
    tick();
    bus.ticlr_clr = 1'b0;
    tick();
    chk("tmr_off_int", bus.timer_int, 0);
`else
    bus.tcfg_we     = 1'b1;
    bus.tcfg_wvalue = 32'h0000_0009;
    tick();
    bus.tcfg_we = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    chk("notmr_tval", bus.tval, 0);
    chk("notmr_int", bus.timer_int, 0);
`endif

    // Random transactions
    for (int n = 0; n < 40; n++) begin
      rv = ($urandom_range(0, 3) == 0) ? 5'h0 : 5'($urandom);
      ri = ($urandom_range(0, 3) == 0) ? 13'($urandom) : 13'h0;
      run_txn({$urandom} & 32'hFFFF_FFFC, rv, 1'($urandom), ri, 1'($urandom),
              $urandom, $urandom, int'($urandom_range(0, 4)), 1'($urandom));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
